// File: rtl/crc5_checker.sv
// Serial CRC-5 (x^5+x^2+x+1) checker for 12-bit {data[6:0], crc[4:0]} codewords, MSB first.
// Define CRC5_CHK_ERRCNT_EN to add the saturating err_count output.
module crc5_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] code_in,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [6:0]  data_out,
  output logic [4:0]  syndrome,
  output logic        crc_ok
`ifdef CRC5_CHK_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One division step: multiply remainder by x, add the incoming bit, fold x^5 back in.
  function automatic logic [4:0] crc5_step(input logic [4:0] lfsr, input logic b);
    crc5_step = {lfsr[3:0], b} ^ (lfsr[4] ? 5'b00111 : 5'b00000);
  endfunction

  state_t      state_q;
  logic [11:0] code_q;
  logic [4:0]  lfsr_q;
  logic [4:0]  lfsr_d;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [6:0]  data_q;
  logic [4:0]  syn_q;
  logic        ok_q;
  logic        bit_s;
`ifdef CRC5_CHK_ERRCNT_EN
  logic [7:0]  err_q;
  logic [7:0]  err_d;
`endif

  // Next remainder from the codeword bit selected by the shift counter.
  always_comb begin
    bit_s  = code_q[4'd11 - cnt_q];
    lfsr_d = crc5_step(lfsr_q, bit_s);
  end

`ifdef CRC5_CHK_ERRCNT_EN
  // Saturating increment of the error counter.
  always_comb begin
    if (err_q == 8'hFF) begin
      err_d = err_q;
    end else begin
      err_d = err_q + 8'd1;
    end
  end
`endif

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= 12'd0;
      lfsr_q      <= 5'd0;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= 7'd0;
      syn_q       <= 5'd0;
      ok_q        <= 1'b0;
`ifdef CRC5_CHK_ERRCNT_EN
      err_q       <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            code_q     <= code_in;
            lfsr_q     <= 5'd0;
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q + 4'd1;
          // Twelfth bit: lfsr_d already holds the full remainder.
          if (cnt_q == 4'd11) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            data_q      <= code_q[11:5];
            syn_q       <= lfsr_d;
            ok_q        <= (lfsr_d == 5'd0);
`ifdef CRC5_CHK_ERRCNT_EN
            if (lfsr_d != 5'd0) begin
              err_q <= err_d;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign syndrome  = syn_q;
  assign crc_ok    = ok_q;
`ifdef CRC5_CHK_ERRCNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_crc5_checker.sv
// Self-checking bench for crc5_checker: transaction-level reference model with
// polynomial long division, per-cycle compare, directed and random stimulus.
module tb_crc5_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] code_in;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  data_out;
  logic [4:0]  syndrome;
  logic        crc_ok;
`ifdef CRC5_CHK_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  crc5_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .syndrome  (syndrome),
    .crc_ok    (crc_ok)
`ifdef CRC5_CHK_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Remainder of a 12-bit codeword modulo x^5+x^2+x+1 by schoolbook long division.
  function automatic logic [4:0] crc_mod(input logic [11:0] cw);
    logic [11:0] r;
    logic [11:0] g;
    r = cw;
    for (int i = 11; i >= 5; i--) begin
      if (r[i]) begin
        g = 12'b0000_0010_0111 << (i - 5);
        r = r ^ g;
      end
    end
    return r[4:0];
  endfunction

  function automatic logic [11:0] encode(input logic [6:0] d);
    return {d, crc_mod({d, 5'b00000})};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a codeword is busy for 12 cycles, then waits for out_ready.
  int          cyc = 0;
  int          n_acc = 0;
  int          last_acc = 0;
  int          prev_acc = 0;
  bit          m_busy = 1'b0;
  int          m_age = 0;
  logic [11:0] m_code = 12'd0;
  logic [6:0]  e_data = 7'd0;
  logic [4:0]  e_syn = 5'd0;
  logic        e_ok = 1'b0;
  logic [7:0]  e_err = 8'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      e_data <= 7'd0;
      e_syn  <= 5'd0;
      e_ok   <= 1'b0;
      e_err  <= 8'd0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy   <= 1'b1;
        m_age    <= 0;
        m_code   <= code_in;
        n_acc    <= n_acc + 1;
        prev_acc <= last_acc;
        last_acc <= cyc;
      end
    end else if (m_age < 12) begin
      m_age <= m_age + 1;
      if (m_age == 11) begin
        e_data <= m_code[11:5];
        e_syn  <= crc_mod(m_code);
        e_ok   <= (crc_mod(m_code) == 5'd0);
        if (crc_mod(m_code) != 5'd0 && e_err != 8'hFF) e_err <= e_err + 8'd1;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(!m_busy));
      chk("out_valid", int'(out_valid), int'(m_busy && m_age == 12));
      chk("data_out", int'(data_out), int'(e_data));
      chk("syndrome", int'(syndrome), int'(e_syn));
      chk("crc_ok", int'(crc_ok), int'(e_ok));
`ifdef CRC5_CHK_ERRCNT_EN
      chk("err_count", int'(err_count), int'(e_err));
`endif
    end
  end

  task automatic xfer(input logic [11:0] code, input int hold, input bit poke,
                      output int lat, output logic [6:0] d, output logic [4:0] s,
                      output logic ok);
    int n;
    n = 0;
    lat = -1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(in_ready), 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = code;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    d  = data_out;
    s  = syndrome;
    ok = crc_ok;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        code_in  = 12'($urandom);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          a0;
    int          n;
    logic [6:0]  d;
    logic [4:0]  s;
    logic        ok;
    logic [11:0] rc;

    rst = 1'b1; in_valid = 1'b0; code_in = 12'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_syndrome", int'(syndrome), 0);
    rst = 1'b0;
    @(negedge clk);

    // Good codeword, immediate consume.
    xfer(12'h80D, 0, 1'b0, lat, d, s, ok);
    chk("lat_80D", lat, 12);
    chk("data_80D", int'(d), 32'h40);
    chk("syn_80D", int'(s), 0);
    chk("ok_80D", int'(ok), 1);

    // Corrupted codeword held in DONE for 20 cycles while new codewords are offered.
    xfer(12'h80C, 20, 1'b1, lat, d, s, ok);
    chk("lat_80C", lat, 12);
    chk("data_80C", int'(d), 32'h40);
    chk("syn_80C", int'(s), 1);
    chk("ok_80C", int'(ok), 0);
    chk("held_data", int'(data_out), 32'h40);
`ifdef CRC5_CHK_ERRCNT_EN
    chk("err_after_80C", int'(err_count), 1);
`endif

    // Back-to-back acceptance with in_valid and out_ready held high.
    a0 = n_acc;
    out_ready = 1'b1; in_valid = 1'b1; code_in = 12'h027;
    n = 0;
    while (n_acc < a0 + 1 && n < 40) begin @(negedge clk); n++; end
    code_in = 12'h000;
    n = 0;
    while (n_acc < a0 + 2 && n < 40) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc - a0, 2);
    chk("b2b_spacing", last_acc - prev_acc, 14);
    chk("b2b_first_data", int'(data_out), 1);
    chk("b2b_first_ok", int'(crc_ok), 1);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("b2b_second_valid", int'(out_valid), 1);
    chk("b2b_second_data", int'(data_out), 0);
    chk("b2b_second_ok", int'(crc_ok), 1);
    @(negedge clk);
    out_ready = 1'b0;

    // Abort a bad codeword with reset on its 6th shift cycle.
    in_valid = 1'b1; code_in = 12'h80C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_valid", int'(out_valid), 0);
      @(negedge clk);
    end
`ifdef CRC5_CHK_ERRCNT_EN
    chk("abort_err", int'(err_count), 0);
`endif

    // Random traffic: valid and corrupted codewords, random backpressure, rare resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      rc        = 12'($urandom);
      code_in   = ($urandom_range(0, 1) == 0) ? encode(rc[6:0]) : rc;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);

`ifdef CRC5_CHK_ERRCNT_EN
    // Saturation: 260 consecutive bad codewords.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a0 = n_acc;
    out_ready = 1'b1; in_valid = 1'b1; code_in = 12'h80C;
    n = 0;
    while (n_acc < a0 + 260 && n < 4000) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    chk("sat_accepts", n_acc - a0, 260);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("sat_err", int'(err_count), 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc5_checker.md
CRC5_CHECKER -- requirements
Module: crc5_checker

Interface
REQ-001 No parameters; widths fixed: codeword 12 bits = {data[6:0], crc[4:0]}, generator x^5+x^2+x+1.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  codeword offered on code_in.
REQ-005 code_in  input  12  received codeword, MSB (bit 11) transmitted first.
REQ-006 in_ready  output  1  checker can accept a codeword; high only in IDLE.
REQ-007 out_valid  output  1  result valid; high only in DONE.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 data_out  output  7  code_in[11:5] of the accepted codeword.
REQ-010 syndrome  output  5  remainder of codeword mod generator.
REQ-011 crc_ok  output  1  1 when syndrome == 5'b00000.
REQ-012 err_count  output  8  saturating count of failed codewords; present only with CRC5_CHK_ERRCNT_EN.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; exactly one active.
REQ-014 IDLE: in_valid=1 at a posedge -> latch code_in, clear 5-bit LFSR, clear 4-bit bit counter, go to SHIFT; in_valid=0 -> stay.
REQ-015 SHIFT: each posedge, with b = latched bit (11 - counter): lfsr <= {lfsr[3:0], b} ^ (lfsr[4] ? 5'b00111 : 5'b00000); counter += 1.
REQ-016 SHIFT: the 12th shift (counter == 11) moves to DONE and registers data_out, syndrome (final LFSR value), crc_ok.
REQ-017 Latency: out_valid rises exactly 12 posedges after the accepting posedge; no zero padding bits are shifted.
REQ-018 DONE: outputs held stable while out_ready=0; out_ready=1 at a posedge -> IDLE, out_valid falls next cycle.
REQ-019 in_valid/code_in ignored outside IDLE; a codeword presented during SHIFT/DONE is not accepted (no overlap, no queueing).
REQ-020 Minimum period between acceptances: 14 cycles (1 accept + 12 shift + 1 DONE with out_ready=1).
REQ-021 data_out, syndrome, crc_ok retain last result after leaving DONE until the next transition into DONE.
REQ-022 Syndrome matches the sender's generator: a codeword built by appending the 5-bit remainder of {data,5'b0} mod generator yields syndrome 0.

Reset
REQ-023 rst=1 at a posedge -> state IDLE, in_ready=1, out_valid=0, data_out=0, syndrome=0, crc_ok=0, LFSR=0, counter=0, err_count=0; priority over all other inputs.
REQ-024 rst during SHIFT or DONE aborts the codeword; no result is produced and err_count is not changed by it.

Configuration
REQ-025 Macro CRC5_CHK_ERRCNT_EN defined: err_count port exists, increments by 1 on each transition into DONE with nonzero syndrome, saturates at 8'hFF, never wraps.
REQ-026 Macro CRC5_CHK_ERRCNT_EN undefined: err_count port and counter logic absent; all other behaviour identical.

Verification
REQ-027 Reset then code_in=12'h80D, in_valid 1 cycle -> out_valid exactly 12 cycles after accept; data_out=7'h40, syndrome=5'h00, crc_ok=1.
REQ-028 code_in=12'h80C (bit 0 flipped) -> syndrome=5'h01, crc_ok=0, data_out=7'h40, err_count +1 (if enabled).
REQ-029 code_in=12'h027 then 12'h000 back-to-back with out_ready=1 -> both crc_ok=1, data_out=7'h01 then 7'h00; second accepted no earlier than 14 cycles after first.
REQ-030 Hold out_ready=0 for 20 cycles in DONE while driving in_valid=1 with new code_in -> outputs unchanged, in_ready=0, new codeword not accepted.
REQ-031 Assert rst at 6th SHIFT cycle of a bad codeword -> IDLE next cycle, out_valid never rises, err_count unchanged.
REQ-032 ERRCNT_EN defined: 260 consecutive 12'h80C codewords -> err_count reaches 8'hFF and stays at 8'hFF.
